// File: rtl/prog_truth_table.sv
// prog_truth_table
//   Runtime-programmable truth-table evaluator. Each of N_CH channels is an
//   independent Boolean function of the shared N_IN-bit input vector, held as
//   a 2**N_IN-bit table. New tables shift in serially (MSB of the full
//   N_CH*TT_W vector first) into a shadow register and commit in one cycle.
//   Evaluation is registered with latency 1 and is never stalled by loading.
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid, in_vec      evaluation request and function inputs
//   out_valid, out_vec    registered result; out_vec[c] = table_c[in_vec]
//   cfg_start             begin (or restart) a table load
//   cfg_valid, cfg_bit    serial table bit, taken when cfg_valid & cfg_ready
//   cfg_ready             high while a load is accepting bits
//   cfg_done              one-cycle pulse on the cycle after commit
module prog_truth_table #(
  parameter int unsigned N_IN = 3,
  parameter int unsigned N_CH = 2,
  parameter logic [N_CH*(2**N_IN)-1:0] INIT_TT = 16'h3532
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  output logic [N_CH-1:0] out_vec,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done
);

  localparam int unsigned TT_W = 2**N_IN;
  localparam int unsigned W    = N_CH * TT_W;
  localparam int unsigned CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  if (W > 4096) begin : g_width_check
    $error("prog_truth_table: N_CH*2**N_IN must not exceed 4096");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_active_tt;
  logic [W-1:0]    r_shadow;
  logic [CW-1:0]   r_count;
  logic [N_CH-1:0] r_out_vec;
  logic            r_out_valid;
  logic            r_cfg_ready;
  logic            r_cfg_done;

  logic [N_CH-1:0] w_lookup;
  logic [TT_W-1:0] w_tt;

  always_comb begin
    w_lookup = '0;
    w_tt     = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_tt        = r_active_tt[c*TT_W +: TT_W];
      w_lookup[c] = w_tt[in_vec];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_active_tt <= INIT_TT;
      r_shadow    <= '0;
      r_count     <= '0;
      r_out_vec   <= '0;
      r_out_valid <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_cfg_done  <= 1'b0;
    end else begin
      // Lookup uses the table as it stands before this edge, so a request
      // in the commit cycle still sees the old table.
      if (in_valid) begin
        r_out_vec   <= w_lookup;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end

      r_cfg_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_state     <= S_LOAD;
            r_count     <= '0;
            r_shadow    <= '0;
            r_cfg_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          // A restart wins over a bit offered in the same cycle.
          if (cfg_start) begin
            r_count  <= '0;
            r_shadow <= '0;
          end else if (cfg_valid) begin
            r_shadow <= {r_shadow[W-2:0], cfg_bit};
            r_count  <= r_count + CW'(1);
            if (r_count == LAST) begin
              r_state     <= S_COMMIT;
              r_cfg_ready <= 1'b0;
            end
          end
        end
        S_COMMIT: begin
          r_active_tt <= r_shadow;
          r_state     <= S_IDLE;
          r_cfg_done  <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  assign out_vec   = r_out_vec;
  assign out_valid = r_out_valid;
  assign cfg_ready = r_cfg_ready;
  assign cfg_done  = r_cfg_done;

endmodule
